// File: rtl/a2d_sampler.sv
// Periodic three-channel ADC sampler: interval timer, round-robin channel select and a
// 16-bit SPI master that issues a command word followed by a read word per conversion.
module a2d_sampler #(
    parameter int FAST_SIM = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        cnv_cmplt
);

    localparam int DATA_W = 12;
    localparam int IW     = (FAST_SIM != 0) ? 8 : 14;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CMD    = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] READ   = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;

    logic [2:0]        state;
    logic [IW-1:0]     timer;
    logic              req;
    logic [1:0]        ch_idx;
    logic [2:0]        chnl;
    logic [9:0]        cnt;
    logic [15:0]       tx;
    logic [DATA_W-1:0] rx;
    logic              in_xfer;
    logic              sclk_fall;
    logic              sclk_rise;
    logic              xfer_end;
    logic              start_cmd;
    logic              start_read;

    assign req = &timer;

    always_comb begin
        case (ch_idx)
            2'd0:    chnl = 3'd0;
            2'd1:    chnl = 3'd1;
            default: chnl = 3'd4;
        endcase
    end

    // cnt holds the number of clk edges since SS_n fell: falls at 8+32k, rises at 24+32k,
    // SS_n released after 528 edges.
    assign in_xfer    = (state == CMD) || (state == READ);
    assign sclk_fall  = in_xfer && (cnt[4:0] == 5'd7)  && (cnt <= 10'd487);
    assign sclk_rise  = in_xfer && (cnt[4:0] == 5'd23) && (cnt <= 10'd503);
    assign xfer_end   = in_xfer && (cnt == 10'd527);
    assign start_cmd  = (state == IDLE) && req;
    assign start_read = (state == GAP) && (cnt == 10'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else begin
            timer <= timer + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            cnv_cmplt <= 1'b0;
            batt      <= '0;
            curr      <= '0;
            torque    <= '0;
            ch_idx    <= 2'd0;
        end else begin
            cnv_cmplt <= 1'b0;
            if (sclk_fall) begin
                SCLK <= 1'b0;
                MOSI <= tx[15];
            end else if (sclk_rise) begin
                SCLK <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= CMD;
                        SS_n  <= 1'b0;
                    end
                end
                CMD: begin
                    if (xfer_end) begin
                        state <= GAP;
                        SS_n  <= 1'b1;
                    end
                end
                GAP: begin
                    if (start_read) begin
                        state <= READ;
                        SS_n  <= 1'b0;
                    end
                end
                READ: begin
                    if (xfer_end) begin
                        state     <= UPDATE;
                        SS_n      <= 1'b1;
                        cnv_cmplt <= 1'b1;
                        case (ch_idx)
                            2'd0:    batt   <= rx;
                            2'd1:    curr   <= rx;
                            default: torque <= rx;
                        endcase
                        ch_idx <= (ch_idx == 2'd2) ? 2'd0 : ch_idx + 2'd1;
                    end
                end
                UPDATE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Shift datapath; only the low 12 received bits are kept, the upper nibble shifts out.
    always_ff @(posedge clk) begin
        if (start_cmd || xfer_end || start_read) begin
            cnt <= 10'd0;
        end else begin
            cnt <= cnt + 10'd1;
        end
        if (start_cmd) begin
            tx <= {2'b00, chnl, 11'h000};
        end else if (start_read) begin
            tx <= 16'h0000;
        end else if (sclk_fall) begin
            tx <= {tx[14:0], 1'b0};
        end
        if (sclk_rise) begin
            rx <= {rx[DATA_W-2:0], MISO};
        end
    end

endmodule
